sb_tx_packet_framer: RTL and testbench
======================================

Name: sb_tx_packet_framer

Overview:
- Sideband TX packet framer, directly downstream of the sideband data encoder and the header encoder.
- Joins the 64-bit header and the optional 64-bit data payload into one UCIe sideband packet and inserts the control and data parity bits (CP, DP).
- Hands the packet to the sideband serializer as 64-bit words under a valid/ready handshake: header word first, then the data word if the opcode carries data.

Parameters:
- DATA_TIMEOUT, 16, cycles to wait for the payload after a with-data header before the packet is dropped.
- GAP_CYCLES, 4, idle cycles forced between packets (used only with SB_FRAMER_GAP_EN).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_header  in  64  header from the header encoder; bits [63:62] are ignored and overwritten.
- i_header_valid  in  1  single-cycle pulse, header present.
- i_data  in  64  encoded payload from the data encoder.
- i_data_valid  in  1  single-cycle pulse, payload present.
- i_ser_ready  in  1  serializer accepts o_frame_data this cycle.
- o_frame_data  out  64  current packet word.
- o_frame_valid  out  1  o_frame_data valid.
- o_framer_ready  out  1  framer can accept a new header.
- o_frame_error  out  1  one-cycle pulse: payload timeout, packet dropped.
- o_overrun  out  1  one-cycle pulse: input arrived while it could not be accepted.

Behaviour:
- Reset (i_rst high at posedge): state IDLE; all outputs 0 except o_framer_ready=1; header/data registers, data_pending, counters cleared. Reset mid-packet abandons the packet with no further handshake.
- has_data = (i_header[4:0] == 5'b11011). Any other opcode is header-only.
- CP = XOR of header[61:0]. DP = XOR of data[63:0] when has_data, else 0. Framed header = {DP, CP, header[61:0]}.
- FSM states: IDLE, WAIT_DATA, SEND_HDR, SEND_DATA, GAP.
- IDLE (o_framer_ready=1):
  - i_data_valid alone: latch data, set data_pending.
  - i_header_valid, has_data=0: latch header, go to SEND_HDR. Any pending data is discarded.
  - i_header_valid, has_data=1, and (i_data_valid same cycle or data_pending): latch both (same-cycle data has priority over pending data), go to SEND_HDR.
  - i_header_valid, has_data=1, no data available: go to WAIT_DATA, load timeout counter with DATA_TIMEOUT.
- WAIT_DATA (o_framer_ready=0):
  - i_data_valid: latch data, go to SEND_HDR.
  - Otherwise decrement the counter. When it reaches 0: pulse o_frame_error, clear registers, go to IDLE.
  - i_header_valid here: ignored, pulse o_overrun.
- SEND_HDR: o_frame_valid=1, o_frame_data = framed header, held stable until i_ser_ready.
  - On accept with has_data: go to SEND_DATA.
  - On accept without has_data: go to GAP if SB_FRAMER_GAP_EN, else IDLE.
- SEND_DATA: o_frame_valid=1, o_frame_data = data, held until i_ser_ready. On accept: go to GAP or IDLE, clear data_pending.
- Overrun rules:
  - Outside IDLE, i_header_valid pulses o_overrun and is ignored.
  - Outside IDLE/WAIT_DATA, i_data_valid pulses o_overrun and is ignored.
  - In IDLE, i_data_valid while data_pending already set overwrites the stored data and pulses o_overrun.
- Latency: header pulse at cycle N (data available) gives o_frame_valid at N+1. Back-to-back ready gives one word per cycle.
- o_frame_data = 0 whenever o_frame_valid=0.

Optional Feature:
- Macro SB_FRAMER_GAP_EN.
- Defined: after the last word of a packet is accepted, the FSM spends exactly GAP_CYCLES cycles in GAP with o_framer_ready=0, then returns to IDLE.
  - Inputs arriving during GAP pulse o_overrun and are ignored.
- Undefined: the GAP state does not exist. The FSM returns to IDLE directly, so a new header can be accepted the cycle after the final accept.

Test Plan:
- Header-only: header opcode 5'b10010, other bits 0x0000_0000_0000_0012, ready=1 -> one word, CP=0, DP=0, o_frame_data=0x0000_0000_0000_0012 at N+1, then o_frame_valid=0.
- With data, same cycle: opcode 5'b11011, data=0x0000_0000_0000_0001, ready=1 -> header word with DP=1 at N+1, data word 0x1 at N+2.
- Data before header: data pulse at N (data 0x3, DP=0), header pulse at N+3 -> header at N+4, data at N+5, no o_overrun.
- Timeout: with-data header, no data for 16 cycles -> o_frame_error pulses once on cycle 17, o_frame_valid never asserted, o_framer_ready=1 on the next cycle.
- Backpressure: i_ser_ready=0 for 5 cycles during SEND_HDR -> o_frame_data stable; a second header pulse in that window -> o_overrun=1 for one cycle, second header never transmitted.
- Reset mid-SEND_DATA: i_rst high for 1 cycle -> next cycle o_frame_valid=0, o_framer_ready=1. With SB_FRAMER_GAP_EN, GAP_CYCLES=4: after a normal final accept, o_framer_ready stays 0 for exactly 4 cycles.

Source files
------------

// File: rtl/sb_tx_packet_framer_if.sv
// rtl/sb_tx_packet_framer_if.sv - header/data inputs and serializer-side handshake of the sideband TX framer
interface sb_tx_packet_framer_if;
    logic [63:0] i_header;
    logic        i_header_valid;
    logic [63:0] i_data;
    logic        i_data_valid;
    logic        i_ser_ready;
    logic [63:0] o_frame_data;
    logic        o_frame_valid;
    logic        o_framer_ready;
    logic        o_frame_error;
    logic        o_overrun;

    modport slave (
        input  i_header, i_header_valid, i_data, i_data_valid, i_ser_ready,
        output o_frame_data, o_frame_valid, o_framer_ready, o_frame_error, o_overrun
    );

    modport master (
        output i_header, i_header_valid, i_data, i_data_valid, i_ser_ready,
        input  o_frame_data, o_frame_valid, o_framer_ready, o_frame_error, o_overrun
    );
endinterface

// File: rtl/sb_tx_packet_framer.sv
// rtl/sb_tx_packet_framer.sv - joins header and optional payload into a sideband packet with CP/DP parity
// Optional inter-packet idle gap enabled by SB_FRAMER_GAP_EN.
module sb_tx_packet_framer #(
    parameter int DATA_TIMEOUT = 16,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    sb_tx_packet_framer_if.slave    bus
);

    localparam int CNT_MAX = (DATA_TIMEOUT > GAP_CYCLES) ? DATA_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [4:0] OPC_WITH_DATA = 5'b11011;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        SEND_HDR,
        SEND_DATA
`ifdef SB_FRAMER_GAP_EN
        , GAP
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [61:0]        header_q, header_d;
    logic [63:0]        data_q, data_d;
    logic               data_pending_q, data_pending_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               hdr_in_has_data;
    logic               hdr_q_has_data;
    logic [63:0]        framed_header;
    logic [63:0]        frame_data;
    logic               frame_valid;
    logic               framer_ready;
    logic               frame_error;
    logic               overrun;
    logic               unused_hdr_bits;

    // Bits [63:62] of the incoming header are replaced by DP/CP, so they are never stored.
    assign unused_hdr_bits = ^bus.i_header[63:62];

    assign hdr_in_has_data = (bus.i_header[4:0] == OPC_WITH_DATA);
    assign hdr_q_has_data  = (header_q[4:0] == OPC_WITH_DATA);
    assign framed_header   = {(hdr_q_has_data ? ^data_q : 1'b0), ^header_q, header_q};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= IDLE;
            header_q       <= '0;
            data_q         <= '0;
            data_pending_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            header_q       <= header_d;
            data_q         <= data_d;
            data_pending_q <= data_pending_d;
            cnt_q          <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        header_d       = header_q;
        data_d         = data_q;
        data_pending_d = data_pending_q;
        cnt_d          = cnt_q;
        frame_data     = '0;
        frame_valid    = 1'b0;
        framer_ready   = 1'b0;
        frame_error    = 1'b0;
        overrun        = 1'b0;

        case (state_q)
            IDLE: begin
                framer_ready = 1'b1;
                overrun      = bus.i_data_valid && data_pending_q;
                if (bus.i_header_valid) begin
                    header_d       = bus.i_header[61:0];
                    data_pending_d = 1'b0;
                    if (!hdr_in_has_data) begin
                        data_d  = '0;
                        state_d = SEND_HDR;
                    end else if (bus.i_data_valid) begin
                        data_d  = bus.i_data;
                        state_d = SEND_HDR;
                    end else if (data_pending_q) begin
                        state_d = SEND_HDR;
                    end else begin
                        cnt_d   = CNT_W'(DATA_TIMEOUT);
                        state_d = WAIT_DATA;
                    end
                end else if (bus.i_data_valid) begin
                    data_d         = bus.i_data;
                    data_pending_d = 1'b1;
                end
            end

            WAIT_DATA: begin
                overrun = bus.i_header_valid;
                if (bus.i_data_valid) begin
                    data_d  = bus.i_data;
                    state_d = SEND_HDR;
                end else if (cnt_q == '0) begin
                    frame_error = 1'b1;
                    header_d    = '0;
                    data_d      = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            SEND_HDR: begin
                frame_valid = 1'b1;
                frame_data  = framed_header;
                overrun     = bus.i_header_valid || bus.i_data_valid;
                if (bus.i_ser_ready) begin
                    if (hdr_q_has_data) begin
                        state_d = SEND_DATA;
                    end else begin
`ifdef SB_FRAMER_GAP_EN
                        cnt_d   = CNT_W'(GAP_CYCLES - 1);
                        state_d = GAP;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end

            SEND_DATA: begin
                frame_valid = 1'b1;
                frame_data  = data_q;
                overrun     = bus.i_header_valid || bus.i_data_valid;
                if (bus.i_ser_ready) begin
                    data_pending_d = 1'b0;
`ifdef SB_FRAMER_GAP_EN
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                    state_d = GAP;
`else
                    state_d = IDLE;
`endif
                end
            end

`ifdef SB_FRAMER_GAP_EN
            GAP: begin
                overrun = bus.i_header_valid || bus.i_data_valid;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    assign bus.o_frame_data   = frame_data;
    assign bus.o_frame_valid  = frame_valid;
    assign bus.o_framer_ready = framer_ready;
    assign bus.o_frame_error  = frame_error;
    assign bus.o_overrun      = overrun;

endmodule

// File: tb/tb_sb_tx_packet_framer.sv
// tb/tb_sb_tx_packet_framer.sv - randomized bench for sb_tx_packet_framer against a word-queue reference model
module tb_sb_tx_packet_framer;

    localparam int DATA_TIMEOUT = 16;
    localparam int GAP_CYCLES   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sb_tx_packet_framer_if bus ();

    sb_tx_packet_framer #(
        .DATA_TIMEOUT (DATA_TIMEOUT),
        .GAP_CYCLES   (GAP_CYCLES)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: words still owed to the serializer, plus absolute-cycle deadlines.
    logic [63:0] m_q[$];
    bit          m_wait;
    logic [63:0] m_wait_hdr;
    int          m_deadline;
    int          m_gap;
    bit          m_pend_v;
    logic [63:0] m_pend;
    int          cyc;

    logic [63:0] o_data;
    logic        o_valid, o_ready, o_err, o_ovr;

    function automatic bit is_wd(input logic [63:0] h);
        return h[4:0] == 5'b11011;
    endfunction

    function automatic logic [63:0] frame_hdr(input logic [63:0] h, input logic [63:0] d, input bit hd);
        return {(hd ? ^d : 1'b0), ^h[61:0], h[61:0]};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_wait   = 0;
        m_gap    = 0;
        m_pend_v = 0;
        m_pend   = '0;
    endtask

    task automatic step(input bit rs, input bit hv, input logic [63:0] h,
                        input bit dv, input logic [63:0] d, input bit rdy);
        bit          idle;
        bit          exp_valid, exp_err, exp_ovr;
        logic [63:0] exp_data;
        @(posedge clk);
        #1;
        rst                = rs;
        bus.i_header_valid = hv;
        bus.i_header       = h;
        bus.i_data_valid   = dv;
        bus.i_data         = d;
        bus.i_ser_ready    = rdy;
        @(negedge clk);
        o_data  = bus.o_frame_data;
        o_valid = bus.o_frame_valid;
        o_ready = bus.o_framer_ready;
        o_err   = bus.o_frame_error;
        o_ovr   = bus.o_overrun;

        idle      = (m_q.size() == 0) && !m_wait && (m_gap == 0);
        exp_valid = m_q.size() > 0;
        exp_data  = exp_valid ? m_q[0] : 64'h0;
        exp_err   = m_wait && !dv && (cyc == m_deadline);
        exp_ovr   = (hv && !idle) || (dv && !idle && !m_wait) || (dv && idle && m_pend_v);
        check("frame_valid", o_valid, exp_valid);
        check("frame_data", o_data, exp_data);
        check("framer_ready", o_ready, idle);
        check("frame_error", o_err, exp_err);
        check("overrun", o_ovr, exp_ovr);

        if (rs) begin
            model_reset();
        end else begin
            if (m_gap > 0) m_gap--;
            if (m_q.size() > 0 && rdy) begin
                void'(m_q.pop_front());
`ifdef SB_FRAMER_GAP_EN
                if (m_q.size() == 0) m_gap = GAP_CYCLES;
`endif
            end
            if (m_wait) begin
                if (dv) begin
                    m_q.push_back(frame_hdr(m_wait_hdr, d, 1));
                    m_q.push_back(d);
                    m_wait = 0;
                end else if (cyc == m_deadline) begin
                    m_wait = 0;
                end
            end else if (idle) begin
                if (hv) begin
                    if (!is_wd(h)) begin
                        m_q.push_back(frame_hdr(h, 64'h0, 0));
                    end else if (dv || m_pend_v) begin
                        m_q.push_back(frame_hdr(h, dv ? d : m_pend, 1));
                        m_q.push_back(dv ? d : m_pend);
                    end else begin
                        m_wait     = 1;
                        m_wait_hdr = h;
                        m_deadline = cyc + DATA_TIMEOUT + 1;
                    end
                    m_pend_v = 0;
                end else if (dv) begin
                    m_pend   = d;
                    m_pend_v = 1;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 64'h0, 0, 64'h0, 1);
    endtask

    initial begin
        logic [63:0] h, d;
        bit          hv, dv, rdy, rs;

        rst                = 1'b1;
        bus.i_header_valid = 1'b0;
        bus.i_header       = '0;
        bus.i_data_valid   = 1'b0;
        bus.i_data         = '0;
        bus.i_ser_ready    = 1'b0;
        cyc                = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid", bus.o_frame_valid, 1'b0);
        check("reset_ready", bus.o_framer_ready, 1'b1);
        check("reset_data", bus.o_frame_data, 64'h0);
        check("reset_err", bus.o_frame_error, 1'b0);
        check("reset_ovr", bus.o_overrun, 1'b0);

        // Header-only packet
        step(0, 1, 64'h12, 0, 64'h0, 1);
        step(0, 0, 64'h0, 0, 64'h0, 1);
        check("hdr_only_valid", o_valid, 1'b1);
        check("hdr_only_word", o_data, 64'h0000_0000_0000_0012);
        step(0, 0, 64'h0, 0, 64'h0, 1);
        check("hdr_only_done", o_valid, 1'b0);
        idle_steps(GAP_CYCLES + 1);

        // With-data packet, header and payload in the same cycle
        step(0, 1, 64'h1B, 1, 64'h1, 1);
        step(0, 0, 64'h0, 0, 64'h0, 1);
        check("wd_hdr_word", o_data, 64'h8000_0000_0000_001B);
        step(0, 0, 64'h0, 0, 64'h0, 1);
        check("wd_data_word", o_data, 64'h1);
        idle_steps(GAP_CYCLES + 2);

        // Payload arrives three cycles ahead of its header
        step(0, 0, 64'h0, 1, 64'h3, 1);
        idle_steps(2);
        step(0, 1, 64'h1B, 0, 64'h0, 1);
        step(0, 0, 64'h0, 0, 64'h0, 1);
        check("early_hdr_word", o_data, 64'h0000_0000_0000_001B);
        step(0, 0, 64'h0, 0, 64'h0, 1);
        check("early_data_word", o_data, 64'h3);
        check("early_no_ovr", o_ovr, 1'b0);
        idle_steps(GAP_CYCLES + 2);

        // Payload timeout
        step(0, 1, 64'h1B, 0, 64'h0, 1);
        idle_steps(DATA_TIMEOUT);
        check("timeout_not_yet", o_err, 1'b0);
        step(0, 0, 64'h0, 0, 64'h0, 1);
        check("timeout_err", o_err, 1'b1);
        step(0, 0, 64'h0, 0, 64'h0, 1);
        check("timeout_ready_after", o_ready, 1'b1);
        check("timeout_no_valid", o_valid, 1'b0);

        // Backpressure with a second header arriving mid-stall
        step(0, 1, 64'h0123_4567_89AB_CD12, 0, 64'h0, 0);
        step(0, 0, 64'h0, 0, 64'h0, 0);
        step(0, 0, 64'h0, 0, 64'h0, 0);
        step(0, 1, 64'h0000_0000_0000_0052, 0, 64'h0, 0);
        check("bp_overrun", o_ovr, 1'b1);
        step(0, 0, 64'h0, 0, 64'h0, 0);
        check("bp_overrun_once", o_ovr, 1'b0);
        step(0, 0, 64'h0, 0, 64'h0, 0);
        step(0, 0, 64'h0, 0, 64'h0, 1);
        idle_steps(GAP_CYCLES + 3);
        check("bp_single_packet", o_valid, 1'b0);

        // Reset during the data word
        step(0, 1, 64'h1B, 1, 64'h55, 1);
        step(0, 0, 64'h0, 0, 64'h0, 1);
        step(1, 0, 64'h0, 0, 64'h0, 0);
        check("rst_mid_valid_before", o_valid, 1'b1);
        step(0, 0, 64'h0, 0, 64'h0, 1);
        check("rst_mid_valid", o_valid, 1'b0);
        check("rst_mid_ready", o_ready, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            rs  = ($urandom_range(0, 299) == 0);
            hv  = !rs && ($urandom_range(0, 5) == 0);
            dv  = !rs && ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            h   = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) h[4:0] = 5'b11011;
            d   = {$urandom, $urandom};
            step(rs, hv, h, dv, d, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
